// File: rtl/pattern_pkg.sv
// Shared constants, field offsets and FSM state type for the pattern buffer write path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pattern_pkg;

  localparam int BUF_SIZE  = 22;
  localparam int BUF_WIDTH = 8;
  localparam int NO_BUFS   = 8;
  localparam int BUFP_W    = 3;
  localparam int FIELD_W   = 5;

  // Field offsets inside one pattern buffer (first and last named slots)
  localparam int PDRIVE  = 0;
  localparam int NTWEAK0 = 14;
  localparam int NTWEAK1 = 15;
  localparam int NTWEAK2 = 16;
  localparam int NTWEAK3 = 17;
  localparam int NTWEAK4 = 18;
  localparam int NTWEAK5 = 19;
  localparam int NTWEAK6 = 20;
  localparam int NTWEAK7 = 21;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

  // Field index following f, wrapping at the end of the buffer
  function automatic logic [FIELD_W-1:0] next_field(input logic [FIELD_W-1:0] f);
    return (f == FIELD_W'(BUF_SIZE - 1)) ? '0 : f + FIELD_W'(1);
  endfunction

endpackage

// File: rtl/pattern_load_ctrl_if.sv
// Host burst-load stream, pat single-write request and pattern buffer write command.
// Latency: n/a (wires only); ld_csum exists only when LOAD_CHECKSUM_EN is defined.
// Backpressure: ld_ready from the controller throttles the host byte stream.
interface pattern_load_ctrl_if;
  import pattern_pkg::*;

  logic                 ld_start;
  logic [BUFP_W-1:0]    ld_buf;
  logic [FIELD_W-1:0]   ld_field;
  logic [FIELD_W-1:0]   ld_count;
  logic [BUF_WIDTH-1:0] ld_data;
  logic                 ld_valid;
  logic                 ld_ready;
  logic                 ld_busy;
  logic                 ld_done;
  logic                 ld_err;
`ifdef LOAD_CHECKSUM_EN
  logic [BUF_WIDTH-1:0] ld_csum;
`endif
  logic                 pat_wr;
  logic [BUFP_W-1:0]    pat_buf;
  logic [FIELD_W-1:0]   pat_field;
  logic [BUF_WIDTH-1:0] pat_data;
  logic [BUFP_W-1:0]    bufp_out;
  logic [FIELD_W-1:0]   fieldwp_out;
  logic [BUF_WIDTH-1:0] field_in_out;
  logic                 field_write_out;

  // Controller side
  modport slave (
    input  ld_start, ld_buf, ld_field, ld_count, ld_data, ld_valid,
    input  pat_wr, pat_buf, pat_field, pat_data,
    output ld_ready, ld_busy, ld_done, ld_err,
`ifdef LOAD_CHECKSUM_EN
    output ld_csum,
`endif
    output bufp_out, fieldwp_out, field_in_out, field_write_out
  );

  // Host / pat / buffer side
  modport master (
    output ld_start, ld_buf, ld_field, ld_count, ld_data, ld_valid,
    output pat_wr, pat_buf, pat_field, pat_data,
    input  ld_ready, ld_busy, ld_done, ld_err,
`ifdef LOAD_CHECKSUM_EN
    input  ld_csum,
`endif
    input  bufp_out, fieldwp_out, field_in_out, field_write_out
  );

endinterface

// File: rtl/pattern_wr_arb.sv
// Fixed-priority 2:1 write arbiter (pat over host) with registered write command.
// Latency: 1 clk from winning request to o_field_write.
// Backpressure: none here; the caller must hold off host writes while pat is active.
module pattern_wr_arb
  import pattern_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_pat_wr,
  input  logic [BUFP_W-1:0]    i_pat_buf,
  input  logic [FIELD_W-1:0]   i_pat_field,
  input  logic [BUF_WIDTH-1:0] i_pat_data,
  input  logic                 i_host_wr,
  input  logic [BUFP_W-1:0]    i_host_buf,
  input  logic [FIELD_W-1:0]   i_host_field,
  input  logic [BUF_WIDTH-1:0] i_host_data,
  output logic [BUFP_W-1:0]    o_bufp,
  output logic [FIELD_W-1:0]   o_fieldwp,
  output logic [BUF_WIDTH-1:0] o_field_in,
  output logic                 o_field_write
);

  logic [BUFP_W-1:0]    r_bufp;
  logic [FIELD_W-1:0]   r_fieldwp;
  logic [BUF_WIDTH-1:0] r_field_in;
  logic                 r_field_write;

  // Register the winning write; address/data hold when nobody writes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bufp        <= '0;
      r_fieldwp     <= '0;
      r_field_in    <= '0;
      r_field_write <= 1'b0;
    end else begin
      r_field_write <= i_pat_wr | i_host_wr;
      if (i_pat_wr) begin
        r_bufp     <= i_pat_buf;
        r_fieldwp  <= i_pat_field;
        r_field_in <= i_pat_data;
      end else if (i_host_wr) begin
        r_bufp     <= i_host_buf;
        r_fieldwp  <= i_host_field;
        r_field_in <= i_host_data;
      end
    end
  end

  assign o_bufp        = r_bufp;
  assign o_fieldwp     = r_fieldwp;
  assign o_field_in    = r_field_in;
  assign o_field_write = r_field_write;

endmodule

// File: rtl/pattern_load_ctrl.sv
// Burst-load sequencer for the pattern buffer field-write port; LOAD_CHECKSUM_EN adds ld_csum.
// Latency: 1 clk from accepted host byte or pat request to field_write_out.
// Backpressure: ld_ready drops whenever pat_wr is high or no burst is loading.
module pattern_load_ctrl
  import pattern_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  pattern_load_ctrl_if.slave  bus
);

  state_e               r_state, w_state_nxt;
  logic [BUFP_W-1:0]    r_buf, w_buf_nxt;
  logic [FIELD_W-1:0]   r_field, w_field_nxt;
  logic [FIELD_W-1:0]   r_rem, w_rem_nxt;
  logic                 r_err, w_err_nxt;
  logic                 w_csum_clr;
  logic                 w_buf_ok;
  logic                 w_legal;
  logic                 w_ready;
  logic                 w_beat;

  // With a full power-of-two buffer count every ld_buf encoding is a real buffer
  generate
    if (NO_BUFS >= (1 << BUFP_W)) begin : g_buf_full
      assign w_buf_ok = 1'b1;
    end else begin : g_buf_chk
      assign w_buf_ok = (bus.ld_buf < BUFP_W'(NO_BUFS));
    end
  endgenerate

  assign w_legal = (bus.ld_count != '0) &&
                   (bus.ld_count <= FIELD_W'(BUF_SIZE)) &&
                   (bus.ld_field < FIELD_W'(BUF_SIZE)) &&
                   w_buf_ok;

  assign w_ready = (r_state == LOAD) && !bus.pat_wr;
  assign w_beat  = w_ready && bus.ld_valid;

  // State and burst-tracking registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_buf   <= '0;
      r_field <= '0;
      r_rem   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_buf   <= w_buf_nxt;
      r_field <= w_field_nxt;
      r_rem   <= w_rem_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Next-state, burst counters and start validation
  always_comb begin
    w_state_nxt = r_state;
    w_buf_nxt   = r_buf;
    w_field_nxt = r_field;
    w_rem_nxt   = r_rem;
    w_err_nxt   = 1'b0;
    w_csum_clr  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.ld_start) begin
          if (w_legal) begin
            w_state_nxt = LOAD;
            w_buf_nxt   = bus.ld_buf;
            w_field_nxt = bus.ld_field;
            w_rem_nxt   = bus.ld_count;
            w_csum_clr  = 1'b1;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      LOAD: begin
        if (w_beat) begin
          w_field_nxt = next_field(r_field);
          w_rem_nxt   = r_rem - FIELD_W'(1);
          if (r_rem == FIELD_W'(1)) begin
            w_state_nxt = DONE;
          end
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

`ifdef LOAD_CHECKSUM_EN
  logic [BUF_WIDTH-1:0] r_csum;

  // XOR of host bytes in the current burst; pat writes never contribute
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_csum <= '0;
    end else if (w_csum_clr) begin
      r_csum <= '0;
    end else if (w_beat) begin
      r_csum <= r_csum ^ bus.ld_data;
    end
  end

  assign bus.ld_csum = r_csum;
`endif

  assign bus.ld_ready = w_ready;
  assign bus.ld_busy  = (r_state != IDLE);
  assign bus.ld_done  = (r_state == DONE);
  assign bus.ld_err   = r_err;

  pattern_wr_arb u_arb (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_pat_wr      (bus.pat_wr),
    .i_pat_buf     (bus.pat_buf),
    .i_pat_field   (bus.pat_field),
    .i_pat_data    (bus.pat_data),
    .i_host_wr     (w_beat),
    .i_host_buf    (r_buf),
    .i_host_field  (r_field),
    .i_host_data   (bus.ld_data),
    .o_bufp        (bus.bufp_out),
    .o_fieldwp     (bus.fieldwp_out),
    .o_field_in    (bus.field_in_out),
    .o_field_write (bus.field_write_out)
  );

endmodule

// File: tb/tb_pattern_load_ctrl.sv
// Self-checking bench for pattern_load_ctrl: directed table, hand sequences, random bursts.
// Latency: checks the 1 clk write latency every cycle against a behavioural model.
// Backpressure: randomizes ld_valid and pat_wr collisions against the host stream.
module tb_pattern_load_ctrl;
  import pattern_pkg::*;

  logic clk;
  logic rst_n;
  pattern_load_ctrl_if ifc();

  pattern_load_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // Behavioural model: burst bookkeeping in plain integers
  int         m_mode;   // 0 idle, 1 loading, 2 completion cycle
  int         m_buf;
  int         m_field;
  int         m_rem;
  logic [7:0] m_csum;
  logic       e_wr;
  logic       e_err;
  logic [2:0] e_bufp;
  logic [4:0] e_fieldwp;
  logic [7:0] e_data;

  // Observed activity, cleared by each test
  int         n_wr_seen;
  int         n_done_seen;
  int         n_err_seen;
  int         last_fld;

  typedef struct {
    logic [2:0] b;
    logic [4:0] f;
    logic [4:0] c;
    int         exp_wr;
    int         exp_err;
    int         exp_done;
    int         exp_last;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      m_mode = 0; e_wr = 0; e_err = 0;
      e_bufp = 0; e_fieldwp = 0; e_data = 0; m_csum = 0;
    end else begin
      e_wr  = 0;
      e_err = 0;
      if (ifc.pat_wr) begin
        e_wr = 1; e_bufp = ifc.pat_buf; e_fieldwp = ifc.pat_field; e_data = ifc.pat_data;
      end
      if (m_mode == 0) begin
        if (ifc.ld_start) begin
          if (int'(ifc.ld_count) >= 1 && int'(ifc.ld_count) <= 22 &&
              int'(ifc.ld_field) < 22 && int'(ifc.ld_buf) < 8) begin
            m_mode = 1; m_buf = int'(ifc.ld_buf); m_field = int'(ifc.ld_field);
            m_rem = int'(ifc.ld_count); m_csum = 0;
          end else begin
            e_err = 1;
          end
        end
      end else if (m_mode == 1) begin
        if (ifc.ld_valid && !ifc.pat_wr) begin
          e_wr = 1; e_bufp = 3'(m_buf); e_fieldwp = 5'(m_field); e_data = ifc.ld_data;
          m_csum = m_csum ^ ifc.ld_data;
          m_field = (m_field + 1) % 22;
          m_rem = m_rem - 1;
          if (m_rem == 0) m_mode = 2;
        end
      end else begin
        m_mode = 0;
      end
    end
  endtask

  // One clock: inputs are already driven; check ld_ready, advance, check registered outputs
  task automatic tick();
    #1;
    chk("ld_ready", ifc.ld_ready, (m_mode == 1) && !ifc.pat_wr);
    model_edge();
    @(posedge clk);
    #1;
    chk("field_write_out", ifc.field_write_out, e_wr);
    chk("bufp_out", ifc.bufp_out, e_bufp);
    chk("fieldwp_out", ifc.fieldwp_out, e_fieldwp);
    chk("field_in_out", ifc.field_in_out, e_data);
    chk("ld_busy", ifc.ld_busy, m_mode != 0);
    chk("ld_done", ifc.ld_done, m_mode == 2);
    chk("ld_err", ifc.ld_err, e_err);
`ifdef LOAD_CHECKSUM_EN
    chk("ld_csum", ifc.ld_csum, m_csum);
`endif
    if (ifc.field_write_out === 1'b1) begin
      n_wr_seen++;
      last_fld = int'(ifc.fieldwp_out);
    end
    if (ifc.ld_done === 1'b1) n_done_seen++;
    if (ifc.ld_err === 1'b1) n_err_seen++;
  endtask

  task automatic clear_inputs();
    ifc.ld_start = 0; ifc.ld_buf = 0; ifc.ld_field = 0; ifc.ld_count = 0;
    ifc.ld_data = 0; ifc.ld_valid = 0;
    ifc.pat_wr = 0; ifc.pat_buf = 0; ifc.pat_field = 0; ifc.pat_data = 0;
  endtask

  task automatic clear_seen();
    n_wr_seen = 0; n_done_seen = 0; n_err_seen = 0; last_fld = -1;
  endtask

  task automatic run_burst(input logic [2:0] b, input logic [4:0] f, input logic [4:0] c,
                           input int valid_pct, input int pat_pct, input bit rnd_start);
    ifc.ld_start = 1; ifc.ld_buf = b; ifc.ld_field = f; ifc.ld_count = c;
    ifc.ld_valid = 0; ifc.pat_wr = 0;
    tick();
    ifc.ld_start = 0;
    for (int k = 0; k < 400 && m_mode != 0; k++) begin
      ifc.ld_valid  = ($urandom_range(99) < valid_pct);
      ifc.ld_data   = 8'($urandom);
      ifc.pat_wr    = ($urandom_range(99) < pat_pct);
      ifc.pat_buf   = 3'($urandom);
      ifc.pat_field = 5'($urandom);
      ifc.pat_data  = 8'($urandom);
      if (rnd_start) begin
        ifc.ld_start = ($urandom_range(99) < 20);
        ifc.ld_buf   = 3'($urandom);
        ifc.ld_field = 5'($urandom);
        ifc.ld_count = 5'($urandom);
      end
      tick();
    end
    if (m_mode != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL burst_timeout: burst still open after cycle budget at %0t", $time);
    end
    clear_inputs();
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    m_mode = 0; m_buf = 0; m_field = 0; m_rem = 0; m_csum = 0;
    e_wr = 0; e_err = 0; e_bufp = 0; e_fieldwp = 0; e_data = 0;
    clear_seen();
    clear_inputs();

    tbl[0] = '{3'd3, 5'd4,  5'd3,  3,  0, 1, 6};
    tbl[1] = '{3'd0, 5'd20, 5'd4,  4,  0, 1, 1};
    tbl[2] = '{3'd1, 5'd4,  5'd0,  0,  1, 0, 0};
    tbl[3] = '{3'd1, 5'd22, 5'd1,  0,  1, 0, 0};
    tbl[4] = '{3'd1, 5'd0,  5'd23, 0,  1, 0, 0};
    tbl[5] = '{3'd7, 5'd21, 5'd22, 22, 0, 1, 20};
    tbl[6] = '{3'd6, 5'd0,  5'd1,  1,  0, 1, 0};
    tbl[7] = '{3'd5, 5'd0,  5'd22, 22, 0, 1, 21};

    // Reset state
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_field_write", ifc.field_write_out, 0);
    chk("rst_bufp", ifc.bufp_out, 0);
    chk("rst_fieldwp", ifc.fieldwp_out, 0);
    chk("rst_field_in", ifc.field_in_out, 0);
    chk("rst_ready", ifc.ld_ready, 0);
    chk("rst_busy", ifc.ld_busy, 0);
    chk("rst_done", ifc.ld_done, 0);
    chk("rst_err", ifc.ld_err, 0);
    rst_n = 1;
    tick();

    // Directed table: continuous valid, no pat traffic
    for (int i = 0; i < 8; i++) begin
      clear_seen();
      run_burst(tbl[i].b, tbl[i].f, tbl[i].c, 100, 0, 0);
      tick();
      chk($sformatf("tbl%0d_writes", i), n_wr_seen, tbl[i].exp_wr);
      chk($sformatf("tbl%0d_err", i), n_err_seen, tbl[i].exp_err);
      chk($sformatf("tbl%0d_done", i), n_done_seen, tbl[i].exp_done);
      if (tbl[i].exp_wr > 0) chk($sformatf("tbl%0d_last_field", i), last_fld, tbl[i].exp_last);
    end

    // Pat collision on the second host beat
    clear_seen();
    ifc.ld_start = 1; ifc.ld_buf = 3'd1; ifc.ld_field = 5'd0; ifc.ld_count = 5'd3;
    tick();
    ifc.ld_start = 0;
    ifc.ld_valid = 1; ifc.ld_data = 8'hB1;
    tick();
    ifc.pat_wr = 1; ifc.pat_buf = 3'd5; ifc.pat_field = 5'd9; ifc.pat_data = 8'h5A;
    ifc.ld_data = 8'hB2;
    #1;
    chk("coll_ready_low", ifc.ld_ready, 0);
    tick();
    chk("coll_pat_field", ifc.fieldwp_out, 9);
    chk("coll_pat_data", ifc.field_in_out, 8'h5A);
    ifc.pat_wr = 0;
    tick();
    chk("coll_host_data", ifc.field_in_out, 8'hB2);
    ifc.ld_data = 8'hB3;
    tick();
    ifc.ld_valid = 0;
    tick();
    tick();
    chk("coll_total_writes", n_wr_seen, 4);
    chk("coll_done", n_done_seen, 1);

    // Pat write while idle
    ifc.pat_wr = 1; ifc.pat_buf = 3'd7; ifc.pat_field = 5'd31; ifc.pat_data = 8'h3C;
    tick();
    chk("idle_pat_field", ifc.fieldwp_out, 31);
    clear_inputs();
    tick();

    // Checksum burst 0F,F0,33
    clear_seen();
    ifc.ld_start = 1; ifc.ld_buf = 3'd4; ifc.ld_field = 5'd10; ifc.ld_count = 5'd3;
    tick();
    ifc.ld_start = 0; ifc.ld_valid = 1;
    ifc.ld_data = 8'h0F; tick();
    ifc.ld_data = 8'hF0; tick();
    ifc.ld_data = 8'h33; tick();
    ifc.ld_valid = 0;
    #1;
    chk("csum_burst_done", ifc.ld_done, 1);
`ifdef LOAD_CHECKSUM_EN
    chk("csum_value", ifc.ld_csum, 8'hCC);
`endif
    tick();
    tick();

    // Reset mid-burst after 5 beats
    clear_seen();
    ifc.ld_start = 1; ifc.ld_buf = 3'd2; ifc.ld_field = 5'd0; ifc.ld_count = 5'd22;
    tick();
    ifc.ld_start = 0; ifc.ld_valid = 1;
    for (int k = 0; k < 5; k++) begin
      ifc.ld_data = 8'(8'h10 + k);
      tick();
    end
    ifc.ld_valid = 0;
    rst_n = 0;
    tick();
    chk("midrst_fieldwp", ifc.fieldwp_out, 0);
    chk("midrst_busy", ifc.ld_busy, 0);
    rst_n = 1;
    tick();
    tick();
    chk("midrst_writes", n_wr_seen, 5);
    chk("midrst_no_done", n_done_seen, 0);

    // Random bursts with pat collisions, stalls and stray starts
    for (int r = 0; r < 40; r++) begin
      run_burst(3'($urandom), 5'($urandom_range(23)), 5'($urandom_range(24)),
                $urandom_range(40, 100), $urandom_range(0, 40), 1);
      if ($urandom_range(3) == 0) begin
        ifc.pat_wr = 1; ifc.pat_buf = 3'($urandom); ifc.pat_field = 5'($urandom);
        ifc.pat_data = 8'($urandom);
      end
      tick();
      clear_inputs();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
